rv_mem_resp: RTL
================

# rv_mem_resp

Memory responder for the multicycle RISC-V core: a single-port word memory that serves the control plane's load/store requests through a request/ready/rvalid handshake, with a parameterised number of wait states. It sits on the far side of the core's memory interface. It accepts one access at a time, commits writes, returns read data with a one-cycle valid pulse, and can optionally flag misaligned addresses.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at least 4.
- `WAIT_CYCLES`, 2: extra wait states per access, range 0..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request from core.
- `we`  in  1  1 = store, 0 = load; the core's memrw.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data.
- `ready`  out  1  responder idle; request accepted at an edge where `req && ready`.
- `rvalid`  out  1  one-cycle completion pulse for loads and stores.
- `rdata`  out  32  load data; valid when `rvalid=1`.
- `err`  out  1  misaligned-access flag, coincident with `rvalid`.
- `busy`  out  1  access in flight; equals `!ready`.

## Operation
- States: IDLE, WAIT, DONE. Wait counter `cnt` is 4 bits.
- **IDLE:** `ready=1`. On accept, capture `addr`, `we` and `wdata` into holding registers, load `cnt=WAIT_CYCLES`, and go to WAIT. Without an accept, stay in IDLE.
- **WAIT:** if `cnt==0`, commit the access and go to DONE; otherwise decrement `cnt`.
- **Commit** happens at the WAIT→DONE edge:
  - Store: `mem[idx] <= wdata_q`.
  - Load: `rdata <= mem[idx]`.
- **DONE:** `rvalid=1` for exactly one cycle, then IDLE unconditionally.
- **Word index:** `idx = addr_q[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo `4*DEPTH_WORDS` bytes.
- Bytes `addr[1:0]` are ignored unless the misalignment check is compiled in. No byte or halfword access; full words only.
- `req` while `ready=0` is ignored, not queued. The requester holds `req` until accepted.
- Inputs are sampled only at the accept edge; later changes during WAIT/DONE have no effect.
- `rdata` holds its last loaded value until the next load commit; stores do not change it.
- **Reset:**
  - State goes to IDLE, `cnt=0`, `rvalid=0`, `rdata=0`, `err=0`, holding registers 0.
  - An in-flight store not yet committed is dropped.
  - Memory contents are not reset.

## Timing
- Accept at edge E0. WAIT occupies N+1 cycles for `WAIT_CYCLES=N`. Commit at edge E(N+1). `rvalid` is high in the cycle after E(N+1). IDLE is entered at E(N+2).
- Load latency, accept edge to `rvalid`: N+1 edges. `WAIT_CYCLES=0` gives `rvalid` one cycle after accept.
- Throughput: one access per N+3 cycles. The earliest next accept is at edge E(N+3).
- `ready`, `busy` and `rvalid` decode directly from the registered state; no combinational path from inputs.
- A store is visible to a load accepted after its `rvalid`.

## Configuration
- Macro: `RV_MEM_MISALIGN_EN`.
- **Defined:** at accept, `addr[1:0]!=0` is registered as `mis_q`. For such an access:
  - Commit suppresses the store.
  - A load returns `rdata=32'h0`.
  - `err=1` in the DONE cycle alongside `rvalid`.
  - Latency is unchanged.
- **Undefined:** `err` is tied to 0 and `addr[1:0]` is ignored; the access proceeds to the aligned word.

## Test plan
- **Reset:** `rst=0` mid-WAIT of a store of 32'hDEADBEEF to 0x10, then load 0x10 → old contents returned; after reset `ready=1`, `rvalid=0`, `rdata=0`.
- **Store/load, `WAIT_CYCLES=2`:** store 32'hCAFEF00D to 0x40, then load 0x40 → `rvalid` 3 edges after each accept, `rdata=32'hCAFEF00D`, `ready` low exactly 4 cycles per access.
- **Zero wait, `WAIT_CYCLES=0`:** back-to-back loads with `req` held high → accepts every 3 cycles; `rvalid` 1 edge after each accept.
- **Aliasing, `DEPTH_WORDS=1024`:** store 32'h11223344 to 0x1000, then load 0x0 → 32'h11223344.
- **Busy ignore:** pulse `req` with store 0x80 during WAIT of a load → no extra `rvalid`, mem[0x80] unchanged.
- **Misalignment, macro defined:** store 32'hFFFFFFFF to 0x22 → `rvalid=1`, `err=1`, mem[0x20] unchanged; load 0x21 → `rdata=0`, `err=1`. Macro undefined: the same load returns mem[0x20], `err=0`.

Source files
------------

// File: rtl/rv_mem_resp.sv
// Single-port word memory responder with a req/ready/rvalid handshake and WAIT_CYCLES wait states.
// Optional misaligned-address flagging is compiled in with `define RV_MEM_MISALIGN_EN.
module rv_mem_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = WAIT_CYCLES[3:0];

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e         state_q;
   logic [3:0]     cnt_q;
   logic [AW-1:0]  idx_q;
   logic           we_q;
   logic [31:0]    wdata_q;
   logic [31:0]    rdata_q;
   logic           mis_w;
   logic           commit;
   logic           unused_addr;

   logic [31:0] mem [DEPTH_WORDS];

   // Upper address bits alias; byte offset only matters with the misalign check.
   assign unused_addr = ^addr_i;

   assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);
   assign ready_o  = (state_q == S_IDLE);
   assign busy_o   = (state_q != S_IDLE);
   assign rvalid_o = (state_q == S_DONE);
   assign rdata_o  = rdata_q;

`ifdef RV_MEM_MISALIGN_EN
   logic mis_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         mis_q <= 1'b0;
      else if (ready_o && req_i)
         mis_q <= |addr_i[1:0];
   end

   assign mis_w = mis_q;
   assign err_o = rvalid_o && mis_q;
`else
   assign mis_w = 1'b0;
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  idx_q   <= addr_i[AW+1:2];
                  we_q    <= we_i;
                  wdata_q <= wdata_i;
                  cnt_q   <= CNT_INIT;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  // rdata only moves on a load commit; stores leave it alone
                  if (!we_q)
                     rdata_q <= mis_w ? 32'h0 : mem[idx_q];
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memory array has no reset; a reset during WAIT forces IDLE so the store never commits.
   always_ff @(posedge clk_i) begin
      if (commit && we_q && !mis_w)
         mem[idx_q] <= wdata_q;
   end

endmodule
